multicycle_ctrl_fsm: RTL and testbench

- Main control state machine for the sequential (multi-cycle) RV32 core.
- Sits directly upstream of the ALU-control decoder:
  - generates the 2-bit alu_op it consumes;
  - receives back its invalid-function flag.
- Sequences fetch/decode/execute/memory/writeback for R-type (add/sub/or/and), lw, sw and beq.
- Drives every datapath enable and mux select; handshakes with a variable-latency unified memory.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 53 +++++
 rtl/multicycle_ctrl_fsm_out_decode.sv | 67 ++++++
 rtl/multicycle_ctrl_fsm.sv | 123 ++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: states, opcodes,
// ALU op codes, ALU B-source selects and the packed control word.
package multicycle_ctrl_fsm_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXECUTE   = 4'd2,
    ST_ALU_WB    = 4'd3,
    ST_MEM_ADDR  = 4'd4,
    ST_MEM_READ  = 4'd5,
    ST_MEM_WB    = 4'd6,
    ST_MEM_WRITE = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_TRAP      = 4'd9
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM_IS = 2'b10;
  localparam logic [1:0] SRCB_IMM_B  = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_word_t;

  localparam int unsigned CTRL_W = $bits(ctrl_word_t);

endpackage

// File: rtl/multicycle_ctrl_fsm_out_decode.sv
// Purely combinational state -> control-word mapping (Moore part of the FSM).
module ctrl_out_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  output logic [CTRL_W-1:0]  o_ctrl
);

  ctrl_word_t w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (state_e'(i_state))
      ST_FETCH: begin
        // ir_write/pc_write are qualified by mem_ready in the FSM
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.pc_write  = 1'b1;
      end
      ST_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_B;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_EXECUTE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_RS2;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: begin
        w_ctrl.reg_write = 1'b1;
      end
      ST_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM_IS;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_RS2;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = 1'b1;
      end
      ST_TRAP: begin
        w_ctrl.illegal = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32 core.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter bit          TRAP_ON_INVFUNC = 1'b1,
  parameter int unsigned PERF_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                inv_func,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal,
  output logic [STATE_W-1:0]  state_dbg
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]   retired_cnt
`endif
);

  if (PERF_W == 0) begin : g_perf_w_chk
    $error("PERF_W must be nonzero");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CTRL_W-1:0] w_ctrl_bits;
  ctrl_word_t        w_ctrl_dec;
  ctrl_word_t        w_ctrl_out;

  ctrl_out_decode u_out_decode (
    .i_state (STATE_W'(r_state)),
    .o_ctrl  (w_ctrl_bits)
  );

  assign w_ctrl_dec = ctrl_word_t'(w_ctrl_bits);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next state plus mem_ready qualification and reset gating of the control word
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl_out  = w_ctrl_dec;
    case (r_state)
      ST_FETCH: begin
        w_ctrl_out.ir_write = mem_ready;
        w_ctrl_out.pc_write = mem_ready;
        if (mem_ready) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:           w_state_nxt = ST_EXECUTE;
          OP_LOAD, OP_STORE:  w_state_nxt = ST_MEM_ADDR;
          OP_BRANCH:          w_state_nxt = ST_BRANCH;
          default:            w_state_nxt = ST_TRAP;
        endcase
      end
      ST_EXECUTE: begin
        if (inv_func) w_state_nxt = TRAP_ON_INVFUNC ? ST_TRAP : ST_FETCH;
        else          w_state_nxt = ST_ALU_WB;
      end
      ST_ALU_WB:    w_state_nxt = ST_FETCH;
      ST_MEM_ADDR:  w_state_nxt = (opcode == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) w_state_nxt = ST_MEM_WB;
      ST_MEM_WB:    w_state_nxt = ST_FETCH;
      ST_MEM_WRITE: if (mem_ready) w_state_nxt = ST_FETCH;
      ST_BRANCH:    w_state_nxt = ST_FETCH;
      ST_TRAP:      w_state_nxt = ST_TRAP;
      default:      w_state_nxt = ST_FETCH;
    endcase
    if (rst) w_ctrl_out = '0;
  end

  assign pc_write      = w_ctrl_out.pc_write;
  assign pc_write_cond = w_ctrl_out.pc_write_cond;
  assign pc_source     = w_ctrl_out.pc_source;
  assign i_or_d        = w_ctrl_out.i_or_d;
  assign mem_read      = w_ctrl_out.mem_read;
  assign mem_write     = w_ctrl_out.mem_write;
  assign ir_write      = w_ctrl_out.ir_write;
  assign reg_write     = w_ctrl_out.reg_write;
  assign mem_to_reg    = w_ctrl_out.mem_to_reg;
  assign alu_src_a     = w_ctrl_out.alu_src_a;
  assign alu_src_b     = w_ctrl_out.alu_src_b;
  assign alu_op        = w_ctrl_out.alu_op;
  assign illegal       = w_ctrl_out.illegal;
  assign state_dbg     = STATE_W'(r_state);

`ifdef CTRL_PERF_CNT_EN
  logic              w_retire;
  logic [PERF_W-1:0] r_retired_cnt;

  // EXECUTE only reaches FETCH directly when an invalid funct retires silently
  assign w_retire = (w_state_nxt == ST_FETCH) &&
                    ((r_state == ST_ALU_WB)    || (r_state == ST_MEM_WB) ||
                     (r_state == ST_MEM_WRITE) || (r_state == ST_BRANCH) ||
                     (r_state == ST_EXECUTE));

  always_ff @(posedge clk) begin
    if (rst)           r_retired_cnt <= '0;
    else if (w_retire) r_retired_cnt <= r_retired_cnt + PERF_W'(1);
  end

  assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized scoreboard bench for multicycle_ctrl_fsm; instance 0 traps on an
// invalid funct, instance 1 retires it silently. Counter checks need CTRL_PERF_CNT_EN.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned PW = 4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } cw_t;

  typedef struct {
    cw_t           e0;
    cw_t           e1;
    logic          cnt_chk;
    logic [PW-1:0] cnt0;
    logic [PW-1:0] cnt1;
    logic [95:0]   tag;
  } exp_t;

  localparam logic [6:0] O_R = 7'b0110011;
  localparam logic [6:0] O_L = 7'b0000011;
  localparam logic [6:0] O_S = 7'b0100011;
  localparam logic [6:0] O_B = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       inv_func = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write_v [2];
  logic       pc_write_cond_v [2];
  logic       pc_source_v [2];
  logic       i_or_d_v [2];
  logic       mem_read_v [2];
  logic       mem_write_v [2];
  logic       ir_write_v [2];
  logic       reg_write_v [2];
  logic       mem_to_reg_v [2];
  logic       alu_src_a_v [2];
  logic [1:0] alu_src_b_v [2];
  logic [1:0] alu_op_v [2];
  logic       illegal_v [2];
  logic [3:0] state_dbg_v [2];
`ifdef CTRL_PERF_CNT_EN
  logic [PW-1:0] retired_cnt_v [2];
`endif

  exp_t        q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int unsigned ret0 = 0;
  int unsigned ret1 = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    multicycle_ctrl_fsm #(.TRAP_ON_INVFUNC(k == 0), .PERF_W(PW)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .inv_func      (inv_func),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write_v[k]),
      .pc_write_cond (pc_write_cond_v[k]),
      .pc_source     (pc_source_v[k]),
      .i_or_d        (i_or_d_v[k]),
      .mem_read      (mem_read_v[k]),
      .mem_write     (mem_write_v[k]),
      .ir_write      (ir_write_v[k]),
      .reg_write     (reg_write_v[k]),
      .mem_to_reg    (mem_to_reg_v[k]),
      .alu_src_a     (alu_src_a_v[k]),
      .alu_src_b     (alu_src_b_v[k]),
      .alu_op        (alu_op_v[k]),
      .illegal       (illegal_v[k]),
      .state_dbg     (state_dbg_v[k])
`ifdef CTRL_PERF_CNT_EN
      ,
      .retired_cnt   (retired_cnt_v[k])
`endif
    );
  end

  // Expected control word for each step of an instruction's life
  function automatic cw_t x_fetch(input logic rdy);
    cw_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic cw_t x_decode();
    cw_t c = '0;
    c.alu_src_b = 2'b11;
    return c;
  endfunction
  function automatic cw_t x_exec();
    cw_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b10;
    return c;
  endfunction
  function automatic cw_t x_wb(input logic from_mem);
    cw_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = from_mem;
    return c;
  endfunction
  function automatic cw_t x_addr();
    cw_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic cw_t x_mem(input logic wr);
    cw_t c = '0;
    c.mem_read = !wr; c.mem_write = wr; c.i_or_d = 1'b1;
    return c;
  endfunction
  function automatic cw_t x_branch();
    cw_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 1'b1;
    return c;
  endfunction
  function automatic cw_t x_trap();
    cw_t c = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

  function automatic cw_t dut_cw(input int k);
    cw_t c;
    c.pc_write = pc_write_v[k];   c.pc_write_cond = pc_write_cond_v[k];
    c.pc_source = pc_source_v[k]; c.i_or_d = i_or_d_v[k];
    c.mem_read = mem_read_v[k];   c.mem_write = mem_write_v[k];
    c.ir_write = ir_write_v[k];   c.reg_write = reg_write_v[k];
    c.mem_to_reg = mem_to_reg_v[k]; c.alu_src_a = alu_src_a_v[k];
    c.alu_src_b = alu_src_b_v[k]; c.alu_op = alu_op_v[k];
    c.illegal = illegal_v[k];
    return c;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle of stimulus plus the expected response for both instances
  task automatic cyc(input logic r, input logic [6:0] op, input logic inf, input logic rdy,
                     input cw_t e0, input cw_t e1, input logic [95:0] tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; inv_func = inf; mem_ready = rdy;
    e.e0 = e0; e.e1 = e1; e.cnt_chk = !r;
    e.cnt0 = PW'(ret0); e.cnt1 = PW'(ret1); e.tag = tag;
    q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 7'($urandom), rbit(), rbit(), '0, '0, "reset");
    ret0 = 0;
    ret1 = 0;
  endtask

  // kind: 0 R-type, 1 lw, 2 sw, 3 beq, 4 bad opcode, 5 R-type with invalid funct
  task automatic run_instr(input int kind, input int fw, input int mw, input int hold,
                           input logic [6:0] bad_op);
    logic [6:0] op;
    case (kind)
      0, 5:    op = O_R;
      1:       op = O_L;
      2:       op = O_S;
      3:       op = O_B;
      default: op = bad_op;
    endcase
    for (int i = 0; i < fw; i++) cyc(1'b0, op, rbit(), 1'b0, x_fetch(1'b0), x_fetch(1'b0), "fetch_wait");
    cyc(1'b0, op, rbit(), 1'b1, x_fetch(1'b1), x_fetch(1'b1), "fetch");
    cyc(1'b0, op, rbit(), rbit(), x_decode(), x_decode(), "decode");
    case (kind)
      0: begin
        cyc(1'b0, op, 1'b0, rbit(), x_exec(), x_exec(), "execute");
        cyc(1'b0, op, rbit(), rbit(), x_wb(1'b0), x_wb(1'b0), "alu_wb");
        ret0++; ret1++;
      end
      1, 2: begin
        cyc(1'b0, op, rbit(), rbit(), x_addr(), x_addr(), "mem_addr");
        for (int i = 0; i < mw; i++)
          cyc(1'b0, op, rbit(), 1'b0, x_mem(kind == 2), x_mem(kind == 2), "mem_wait");
        cyc(1'b0, op, rbit(), 1'b1, x_mem(kind == 2), x_mem(kind == 2), "mem_done");
        if (kind == 1) cyc(1'b0, op, rbit(), rbit(), x_wb(1'b1), x_wb(1'b1), "mem_wb");
        ret0++; ret1++;
      end
      3: begin
        cyc(1'b0, op, rbit(), rbit(), x_branch(), x_branch(), "branch");
        ret0++; ret1++;
      end
      4: begin
        for (int i = 0; i < hold; i++) cyc(1'b0, op, rbit(), rbit(), x_trap(), x_trap(), "trap_hold");
        do_reset(1);
      end
      default: begin
        cyc(1'b0, op, 1'b1, rbit(), x_exec(), x_exec(), "exec_inv");
        ret1++;
        cyc(1'b0, op, rbit(), 1'b0, x_trap(), x_fetch(1'b0), "after_inv");
        do_reset(1);
      end
    endcase
  endtask

  task automatic check_cw(input int k, input cw_t got, input cw_t want, input logic [95:0] tag);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %0s dut%0d: ctrl got %h want %h", tag, k, got, want);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check_cw(0, dut_cw(0), e.e0, e.tag);
        check_cw(1, dut_cw(1), e.e1, e.tag);
`ifdef CTRL_PERF_CNT_EN
        if (e.cnt_chk) begin
          n_total += 2;
          if (retired_cnt_v[0] === e.cnt0) n_pass++;
          else $display("FAIL %0s cnt0: got %0d want %0d", e.tag, retired_cnt_v[0], e.cnt0);
          if (retired_cnt_v[1] === e.cnt1) n_pass++;
          else $display("FAIL %0s cnt1: got %0d want %0d", e.tag, retired_cnt_v[1], e.cnt1);
        end
`endif
      end
    end
  end

  initial begin
    logic [6:0] bop;
    int         kind;
    do_reset(2);
    run_instr(0, 0, 0, 0, 7'd0);
    run_instr(1, 0, 3, 0, 7'd0);
    run_instr(3, 0, 0, 0, 7'd0);
    run_instr(2, 1, 2, 0, 7'd0);
    run_instr(4, 0, 0, 10, 7'b1111111);
    run_instr(5, 0, 0, 0, 7'd0);
    for (int i = 0; i < 17; i++) run_instr(2, 0, 0, 0, 7'd0);
    // abandoned fetch: reset lands while mem_read is high
    cyc(1'b0, O_S, 1'b0, 1'b0, x_fetch(1'b0), x_fetch(1'b0), "fetch_abort");
    do_reset(1);
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind > 5) kind = kind - 6;
      do bop = 7'($urandom);
      while (bop == O_R || bop == O_L || bop == O_S || bop == O_B);
      if ($urandom_range(0, 11) == 0) begin
        cyc(1'b0, O_R, rbit(), 1'b0, x_fetch(1'b0), x_fetch(1'b0), "fetch_abort");
        do_reset(1);
      end
      run_instr(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 10)), bop);
    end
    repeat (3) @(negedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
